// File: rtl/enc83_event_encoder.sv
// 8-to-3 event encoder: synchronised request lines become pending events, emitted
// highest index first over valid/ready. Define ENC83_DEBOUNCE_EN to build per-line debounce.
module enc83_event_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overrun
);
    logic [7:0] s1_q, s2_q, prev_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] lvl, rise, grant, clr;
    logic [2:0] grant_idx;
    logic       load;

`ifdef ENC83_DEBOUNCE_EN
    logic [7:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // A line's accepted level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (32'(cnt_q[i]) + 32'd1 == DEBOUNCE_CYCLES) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = deb_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{DEBOUNCE_CYCLES, CNT_W};
    assign lvl        = s2_q;
`endif

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        // Ascending scan, last hit wins: the highest set bit takes the grant.
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                grant     = 8'b1 << i;
                grant_idx = i[2:0];
            end
        end

        load      = (!valid_q || ready) && (pending_q != 8'h00);
        clr       = load ? grant : 8'h00;
        rise      = lvl & ~prev_q;
        pending_d = (pending_q & ~clr) | rise;
        overrun_d = overrun_q | (|(rise & pending_q & ~clr));

        code_d  = code_q;
        valid_d = valid_q;
        if (load) begin
            code_d  = grant_idx;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= req;
            s2_q      <= s1_q;
            prev_q    <= lvl;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_enc83_event_encoder.sv
// Self-checking bench for enc83_event_encoder; emitted codes are matched against a queue.
module tb_enc83_event_encoder;
`ifdef ENC83_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] sb[$];

    typedef struct {
        logic [7:0]  mask;
        bit          stall;
        int          n;
        logic [23:0] codes;       // emission order, first code in [2:0]
        logic [7:0]  pend_stall;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    enc83_event_encoder #(
        .DEBOUNCE_CYCLES((D == 0) ? 16 : D),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .code(code), .valid(valid),
        .ready(ready), .pending(pending), .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((sb.size() != 0 || valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: code %0d emitted, required no event", code);
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                check("sb_code", code, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mask: 8'h4A, stall: 1'b1, n: 3, codes: 24'({3'd1, 3'd3, 3'd6}), pend_stall: 8'h0A};
        vecs[1] = '{mask: 8'hFF, stall: 1'b1, n: 8,
                    codes: {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, pend_stall: 8'h7F};
        vecs[2] = '{mask: 8'h81, stall: 1'b0, n: 2, codes: 24'({3'd0, 3'd7}), pend_stall: 8'h00};
        vecs[3] = '{mask: 8'h11, stall: 1'b1, n: 2, codes: 24'({3'd0, 3'd4}), pend_stall: 8'h01};
        vecs[4] = '{mask: 8'h24, stall: 1'b0, n: 2, codes: 24'({3'd2, 3'd5}), pend_stall: 8'h00};

        rst = 1'b1; req = 8'h00; ready = 1'b0;
        cycles(3);
        @(negedge clk);
        check("rst_code", code, 0);
        check("rst_valid", valid, 0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(2);

        // single event latency
        ready = 1'b1;
        sb.push_back(3'd5);
        req = 8'h20;
        @(posedge clk);
        repeat (2 + D) @(posedge clk);
        @(negedge clk);
        check("single_pending_set", pending, 8'h20);
        check("single_valid_early", valid, 0);
        @(negedge clk);
        check("single_valid", valid, 1);
        check("single_code", code, 5);
        check("single_pending_clr", pending, 0);
        @(negedge clk);
        check("single_valid_drop", valid, 0);
        @(posedge clk); #1;
        req = 8'h00;
        cycles(D + 6);
        check("single_no_spurious", sb.size(), 0);

        for (int v = 0; v < 5; v++) begin
            ready = !vecs[v].stall;
            for (int k = 0; k < vecs[v].n; k++) sb.push_back(vecs[v].codes[3*k +: 3]);
            req = vecs[v].mask;
            if (vecs[v].stall) begin
                cycles(D + 6);
                check("stall_pending", pending, vecs[v].pend_stall);
                check("stall_valid", valid, 1);
                check("stall_code", code, vecs[v].codes[2:0]);
                ready = 1'b1;
                @(negedge clk);
                for (int k = 1; k < vecs[v].n; k++) begin
                    @(negedge clk);
                    check("burst_valid", valid, 1);
                end
                @(negedge clk);
                check("burst_end_valid", valid, 0);
                @(posedge clk); #1;
            end
            wait_drain("vec_drain");
            check("vec_pending", pending, 0);
            check("vec_overrun", overrun, 0);
            req = 8'h00;
            cycles(D + 6);
        end

        // set and clear of pending[4] in the same cycle
        ready = 1'b0;
        sb.push_back(3'd0);
        req = 8'h01; cycles(D + 4);
        req = 8'h11; cycles(D + 4);
        check("sc_pending_pre", pending, 8'h10);
        check("sc_code_pre", code, 0);
        req = 8'h00; cycles(D + 6);
        sb.push_back(3'd4); sb.push_back(3'd4);
        req = 8'h10;
        @(posedge clk);
        repeat (1 + D) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("sc_pending_kept", pending, 8'h10);
        check("sc_overrun", overrun, 0);
        check("sc_code", code, 4);
        check("sc_valid", valid, 1);
        @(posedge clk); #1;
        wait_drain("sc_drain");
        check("sc_overrun_end", overrun, 0);
        req = 8'h00; cycles(D + 6);

        // overrun: output register busy with code 0, req[2] rises twice
        ready = 1'b0;
        sb.push_back(3'd0); sb.push_back(3'd2);
        req = 8'h01; cycles(D + 4);
        req = 8'h05; cycles(D + 4);
        check("ovr_no_overrun_yet", overrun, 0);
        req = 8'h01; cycles(D + 4);
        req = 8'h05; cycles(D + 4);
        check("ovr_overrun", overrun, 1);
        check("ovr_pending", pending, 8'h04);
        check("ovr_code", code, 0);
        req = 8'h00; ready = 1'b1;
        wait_drain("ovr_drain");
        check("ovr_pending_end", pending, 0);
        check("ovr_sticky", overrun, 1);
        cycles(D + 6);

        // reset mid-operation
        ready = 1'b0;
        req = 8'h01; cycles(D + 4);
        req = 8'h91; cycles(D + 4);
        check("rmo_pending", pending, 8'h90);
        check("rmo_valid", valid, 1);
        req = 8'h80; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        sb.delete();
        sb.push_back(3'd7);
        @(negedge clk);
        check("rmo_code", code, 0);
        check("rmo_valid0", valid, 0);
        check("rmo_pending0", pending, 0);
        check("rmo_overrun0", overrun, 0);
        @(posedge clk);
        repeat (2 + D) @(posedge clk);
        @(negedge clk);
        check("rmo_valid_early", valid, 0);
        @(negedge clk);
        check("rmo_valid7", valid, 1);
        check("rmo_code7", code, 7);
        @(posedge clk); #1;
        req = 8'h00;
        wait_drain("rmo_drain");
        cycles(D + 6);

`ifdef ENC83_DEBOUNCE_EN
        begin
            bit seen;
            seen = 1'b0;
            ready = 1'b1;
            req = 8'h01; cycles(3);
            req = 8'h00;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (valid) seen = 1'b1;
            end
            check("deb_glitch_no_valid", seen, 0);
            @(posedge clk); #1;
            sb.push_back(3'd0);
            req = 8'h01;
            @(posedge clk);
            repeat (5) @(posedge clk);
            #1 req = 8'h00;
            @(posedge clk);
            @(negedge clk);
            check("deb_valid_edge6", valid, 0);
            @(negedge clk);
            check("deb_valid_edge7", valid, 1);
            check("deb_code_edge7", code, 0);
            @(posedge clk); #1;
            wait_drain("deb_drain");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
